// File: rtl/im_boot_loader.sv
// Boot loader: takes a big-endian byte stream (16-bit word count, then 32-bit words)
// and writes it into instruction memory. The core is held in reset until the image is committed.
module im_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam logic [16:0] DEPTH = 17'(2**ADDR_W);

  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DATA, COMMIT_WAIT, DONE_S, ERR_S
  } state_t;

  state_t            state_q;
  logic [15:0]       n_q;
  logic [23:0]       asm_q;
  logic [1:0]        bcnt_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;
  logic [15:0]       words_q;

  logic              xfer;
  logic [15:0]       n_full;

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA: byte_ready = 1'b1;
      default:              byte_ready = 1'b0;
    endcase
  end

  assign xfer   = byte_valid & byte_ready;
  assign n_full = {n_q[15:8], byte_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR_HI;
      n_q        <= '0;
      asm_q      <= '0;
      bcnt_q     <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
    end else begin
      im_we_q <= 1'b0;
      // Count advances at the end of the strobe cycle, so the next word's
      // address is already updated by the time its 4th byte can arrive.
      if (im_we_q) words_q <= words_q + 16'd1;
      case (state_q)
        HDR_HI: if (xfer) begin
          n_q[15:8] <= byte_data;
          state_q   <= HDR_LO;
        end
        HDR_LO: if (xfer) begin
          n_q[7:0] <= byte_data;
          bcnt_q   <= '0;
          if (n_full == 16'd0) begin
            state_q <= COMMIT_WAIT;
          end else if ({1'b0, n_full} > DEPTH) begin
            state_q <= ERR_S;
            err_q   <= 1'b1;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (xfer) begin
          asm_q  <= {asm_q[15:0], byte_data};
          bcnt_q <= bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            im_wdata_q <= {asm_q, byte_data};
            im_addr_q  <= words_q[ADDR_W-1:0];
            im_we_q    <= 1'b1;
            if (words_q == n_q - 16'd1) state_q <= COMMIT_WAIT;
          end
        end
        // Final strobe (if any) is in flight here; core release follows it.
        COMMIT_WAIT: begin
          state_q   <= DONE_S;
          done_q    <= 1'b1;
          cpu_rst_q <= 1'b0;
        end
        DONE_S, ERR_S: if (reload) begin
          state_q   <= HDR_HI;
          n_q       <= '0;
          bcnt_q    <= '0;
          cpu_rst_q <= 1'b1;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          words_q   <= '0;
        end
        default: state_q <= HDR_HI;
      endcase
    end
  end

  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader: small loads, stream gaps, header error,
// empty image, mid-load reset and a full-depth load.
module tb_im_boot_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              reload = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [15:0]       words_loaded;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  im_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_rst(cpu_rst), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && im_we) begin
      wa.push_back(32'(im_addr));
      wd.push_back(im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Called right after the last accepted byte: strobe now, release next cycle.
  task automatic check_finish(input string tag);
    chk({tag, "_done_t1"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_t2"}, 32'(done), 32'd1);
    chk({tag, "_cpurst_t2"}, 32'(cpu_rst), 32'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  logic [7:0] s1 [10];
  int bad;

  initial begin
    s1 = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: two words back-to-back
    wa.delete(); wd.delete();
    for (int i = 0; i < 10; i++) send(s1[i], 0);
    chk("t1_we_t1", 32'(im_we), 32'd1);
    check_finish("t1");
    chk("t1_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("t1_a0", wa[0], 32'd0);
      chk("t1_d0", wd[0], 32'h24010005);
      chk("t1_a1", wa[1], 32'd1);
      chk("t1_d1", wd[1], 32'h08000000);
    end
    chk("t1_words", 32'(words_loaded), 32'd2);
    // Bytes in DONE are refused and change nothing.
    byte_valid = 1'b1; byte_data = 8'hAA;
    chk("t1_ready_done", 32'(byte_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1; byte_valid = 1'b0;
    chk("t1_nwr_after", wa.size(), 32'd2);
    chk("t1_words_after", 32'(words_loaded), 32'd2);

    // Test 2: same stream with 3-cycle gaps after each byte
    do_reload();
    chk("t2_reload_done", 32'(done), 32'd0);
    chk("t2_reload_cpurst", 32'(cpu_rst), 32'd1);
    chk("t2_reload_words", 32'(words_loaded), 32'd0);
    wa.delete(); wd.delete();
    for (int i = 0; i < 10; i++) send(s1[i], (i == 9) ? 0 : 3);
    chk("t2_we_t1", 32'(im_we), 32'd1);
    check_finish("t2");
    chk("t2_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("t2_a0", wa[0], 32'd0);
      chk("t2_d0", wd[0], 32'h24010005);
      chk("t2_a1", wa[1], 32'd1);
      chk("t2_d1", wd[1], 32'h08000000);
    end
    chk("t2_words", 32'(words_loaded), 32'd2);

    // Test 3: N=1025 exceeds depth
    do_reload();
    wa.delete(); wd.delete();
    send(8'h04, 0);
    send(8'h01, 0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_cpurst", 32'(cpu_rst), 32'd1);
    chk("t3_ready", 32'(byte_ready), 32'd0);
    chk("t3_done", 32'(done), 32'd0);
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (4) @(posedge clk);
    #1; byte_valid = 1'b0;
    chk("t3_err_hold", 32'(err), 32'd1);
    chk("t3_nwr", wa.size(), 32'd0);
    do_reload();
    chk("t3_reload_err", 32'(err), 32'd0);
    chk("t3_reload_ready", 32'(byte_ready), 32'd1);
    send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    chk("t3_we_t1", 32'(im_we), 32'd1);
    check_finish("t3");
    chk("t3_nwr2", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      chk("t3_a0", wa[0], 32'd0);
      chk("t3_d0", wd[0], 32'hDEADBEEF);
    end
    chk("t3_words", 32'(words_loaded), 32'd1);

    // Test 4: empty image
    do_reload();
    wa.delete(); wd.delete();
    send(8'h00, 0); send(8'h00, 0);
    chk("t4_we_t1", 32'(im_we), 32'd0);
    check_finish("t4");
    chk("t4_nwr", wa.size(), 32'd0);
    chk("t4_words", 32'(words_loaded), 32'd0);

    // Test 5: reset after 6 of 10 bytes, then full reload
    do_reload();
    wa.delete(); wd.delete();
    for (int i = 0; i < 6; i++) send(s1[i], 0);
    rst = 1'b1;
    #1;
    chk("t5_cpurst", 32'(cpu_rst), 32'd1);
    chk("t5_we", 32'(im_we), 32'd0);
    chk("t5_addr", 32'(im_addr), 32'd0);
    chk("t5_wdata", im_wdata, 32'd0);
    chk("t5_words", 32'(words_loaded), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wa.delete(); wd.delete();
    for (int i = 0; i < 10; i++) send(s1[i], 0);
    check_finish("t5");
    chk("t5_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("t5_a0", wa[0], 32'd0);
      chk("t5_d1", wd[1], 32'h08000000);
    end

    // Test 6: full depth, word i = i
    do_reload();
    wa.delete(); wd.delete();
    send(8'h04, 0); send(8'h00, 0);
    for (int i = 0; i < 1024; i++) begin
      send(8'h00, 0); send(8'h00, 0);
      send(8'(i >> 8), 0); send(8'(i), 0);
    end
    check_finish("t6");
    chk("t6_nwr", wa.size(), 32'd1024);
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 32'(i) || wd[i] !== 32'(i)) bad++;
    chk("t6_all_words", 32'(bad), 32'd0);
    if (wa.size() == 1024) begin
      chk("t6_last_a", wa[1023], 32'd1023);
      chk("t6_last_d", wd[1023], 32'h000003FF);
    end
    chk("t6_words", 32'(words_loaded), 32'd1024);
    chk("t6_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
